// File: rtl/store_align_unit_if.sv
// Store request / data-memory write bundle for store_align_unit.
// The slave modport is the aligner; master is the datapath/memory side.
interface store_align_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_funct3;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        done;
    logic        err;

    modport slave (
        input  req_valid, req_addr, req_data, req_funct3, mem_ready,
        output req_ready, mem_we, mem_addr, mem_wdata, mem_be, done, err
    );

    modport master (
        output req_valid, req_addr, req_data, req_funct3, mem_ready,
        input  req_ready, mem_we, mem_addr, mem_wdata, mem_be, done, err
    );
endinterface

// File: rtl/store_align_unit.sv
// Store byte-lane aligner: SB/SH/SW into a word-addressed write port,
// splitting word-crossing stores into two sequential writes.
module store_align_unit (
    input  logic              clk,
    input  logic              reset,
    store_align_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, FIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  size_q, size_d;
    logic        split_q, split_d;
    logic        err_q, err_d;

    logic        legal;
    logic [1:0]  req_k;
    logic [1:0]  k;
    logic [3:0]  size_mask;
    logic [31:0] size_data;
    logic [2:0]  hi_shift;
    logic [31:0] base_addr;

    always_comb begin
        legal   = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                  (bus.req_funct3 == 3'b010);
        req_k   = bus.req_addr[1:0];
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        split_d = split_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    data_d  = bus.req_data;
                    size_d  = bus.req_funct3[1:0];
                    err_d   = !legal;
                    split_d = ((bus.req_funct3 == 3'b001) && (req_k == 2'd3)) ||
                              ((bus.req_funct3 == 3'b010) && (req_k != 2'd0));
                    state_d = legal ? WR_LO : FIN;
                end
            end
            WR_LO:   if (bus.mem_ready) state_d = split_q ? WR_HI : FIN;
            WR_HI:   if (bus.mem_ready) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Both halves come from one zero-extended operand: the low write shifts it
    // up by k lanes, the high write shifts it down by the lanes already written.
    always_comb begin
        k         = addr_q[1:0];
        hi_shift  = 3'd4 - {1'b0, k};
        base_addr = {addr_q[31:2], 2'b00};
        case (size_q)
            2'b00:   begin size_mask = 4'b0001; size_data = {24'd0, data_q[7:0]};  end
            2'b01:   begin size_mask = 4'b0011; size_data = {16'd0, data_q[15:0]}; end
            default: begin size_mask = 4'b1111; size_data = data_q;                end
        endcase

        bus.req_ready = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_be    = '0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        case (state_q)
            IDLE: bus.req_ready = 1'b1;
            WR_LO: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = base_addr;
                bus.mem_be    = size_mask << k;
                bus.mem_wdata = size_data << {k, 3'b000};
            end
            WR_HI: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = base_addr + 32'd4;
                bus.mem_be    = size_mask >> hi_shift;
                bus.mem_wdata = size_data >> {hi_shift, 3'b000};
            end
            FIN: begin
                bus.done = 1'b1;
                bus.err  = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            split_q <= split_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_store_align_unit.sv
// Bench for store_align_unit: directed table, hand-written reset sequences and
// randomized stores checked against a byte-level memory-write model.
module tb_store_align_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_align_unit_if bus ();

    store_align_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
        int          wlo;
        int          n;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] w0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] w1;
        int          done;
        logic        err;
    } vec_t;

    vec_t tbl [9];

    int          exp_n, exp_done;
    logic        exp_err;
    logic [31:0] exp_addr [4];
    logic [3:0]  exp_be   [4];
    logic [31:0] exp_wd   [4];

    int          obs_n, obs_done;
    logic        obs_err;
    logic [31:0] obs_addr [4];
    logic [3:0]  obs_be   [4];
    logic [31:0] obs_wd   [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: walk the n stored bytes one at a time, placing each into the
    // word that holds its byte address; a new word starts a new memory write.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                         input int waits);
        logic [31:0] b, w;
        int nb;
        exp_n = 0;
        for (int i = 0; i < 4; i++) begin
            exp_addr[i] = '0; exp_be[i] = '0; exp_wd[i] = '0;
        end
        if (f3 > 3'd2) begin
            exp_done = 1;
            exp_err  = 1'b1;
        end else begin
            nb = 1 << f3;
            for (int i = 0; i < nb; i++) begin
                b = a + i;
                w = {b[31:2], 2'b00};
                if (exp_n == 0 || exp_addr[exp_n-1] != w) begin
                    exp_addr[exp_n] = w;
                    exp_n++;
                end
                exp_be[exp_n-1][b[1:0]]       = 1'b1;
                exp_wd[exp_n-1][8*b[1:0] +: 8] = d[8*i +: 8];
            end
            exp_done = exp_n + waits + 1;
            exp_err  = 1'b0;
        end
    endtask

    // Issue one store and observe it to completion; cycle 0 is the accept cycle.
    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                             input int wlo, input int whi);
        int waits_left;
        logic pend;
        logic [31:0] pa, pw;
        logic [3:0] pb;
        for (int t = 0; t < 8 && bus.req_ready !== 1'b1; t++) @(negedge clk);
        chk("req_ready_before_req", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_addr   = a;
        bus.req_data   = d;
        bus.req_funct3 = f3;
        bus.mem_ready  = 1'b1;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom;
        bus.req_data   = $urandom;
        bus.req_funct3 = 3'($urandom);
        obs_n = 0; obs_done = -1; obs_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            obs_addr[i] = '0; obs_be[i] = '0; obs_wd[i] = '0;
        end
        pend = 1'b0; pa = '0; pb = '0; pw = '0;
        waits_left = wlo;
        for (int c = 1; c <= 30; c++) begin
            if (bus.mem_we) begin
                if (pend) begin
                    chk("stall_addr_stable", bus.mem_addr, pa);
                    chk("stall_be_stable", {28'd0, bus.mem_be}, {28'd0, pb});
                    chk("stall_wdata_stable", bus.mem_wdata, pw);
                end
                if (waits_left > 0) begin
                    bus.mem_ready = 1'b0;
                    waits_left--;
                    pend = 1'b1;
                    pa = bus.mem_addr; pb = bus.mem_be; pw = bus.mem_wdata;
                end else begin
                    bus.mem_ready = 1'b1;
                    if (obs_n < 4) begin
                        obs_addr[obs_n] = bus.mem_addr;
                        obs_be[obs_n]   = bus.mem_be;
                        obs_wd[obs_n]   = bus.mem_wdata;
                    end
                    obs_n++;
                    pend = 1'b0;
                    waits_left = whi;
                end
            end else begin
                pend = 1'b0;
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            if (bus.done) begin
                obs_done = c;
                obs_err  = bus.err;
                chk("req_ready_low_in_done", {31'd0, bus.req_ready}, 32'd0);
                chk("mem_we_low_in_done", {31'd0, bus.mem_we}, 32'd0);
                break;
            end
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("req_ready_after_done", {31'd0, bus.req_ready}, 32'd1);
        chk("done_single_pulse", {31'd0, bus.done}, 32'd0);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_nwrites"}, obs_n, exp_n);
        for (int i = 0; i < exp_n && i < 4; i++) begin
            chk({tag, "_addr"}, obs_addr[i], exp_addr[i]);
            chk({tag, "_be"}, {28'd0, obs_be[i]}, {28'd0, exp_be[i]});
            chk({tag, "_wdata"}, obs_wd[i], exp_wd[i]);
        end
        chk({tag, "_done_cycle"}, obs_done, exp_done);
        chk({tag, "_err"}, {31'd0, obs_err}, {31'd0, exp_err});
    endtask

    task automatic load_row(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            exp_addr[i] = '0; exp_be[i] = '0; exp_wd[i] = '0;
        end
        exp_n = v.n;
        exp_addr[0] = v.a0; exp_be[0] = v.be0; exp_wd[0] = v.w0;
        exp_addr[1] = v.a1; exp_be[1] = v.be1; exp_wd[1] = v.w1;
        exp_done = v.done;
        exp_err  = v.err;
    endtask

    initial begin
        tbl[0] = '{32'h0000_1000, 32'hDEAD_BEEF, 3'd2, 0, 1, 32'h1000, 4'b1111, 32'hDEAD_BEEF,
                   32'h0, 4'b0000, 32'h0, 2, 1'b0};
        tbl[1] = '{32'h0000_1003, 32'h0000_00A5, 3'd0, 0, 1, 32'h1000, 4'b1000, 32'hA500_0000,
                   32'h0, 4'b0000, 32'h0, 2, 1'b0};
        tbl[2] = '{32'h0000_1002, 32'h0000_1234, 3'd1, 0, 1, 32'h1000, 4'b1100, 32'h1234_0000,
                   32'h0, 4'b0000, 32'h0, 2, 1'b0};
        tbl[3] = '{32'h0000_1001, 32'h1122_3344, 3'd2, 0, 2, 32'h1000, 4'b1110, 32'h2233_4400,
                   32'h1004, 4'b0001, 32'h0000_0011, 3, 1'b0};
        tbl[4] = '{32'hFFFF_FFFF, 32'h0000_ABCD, 3'd1, 0, 2, 32'hFFFF_FFFC, 4'b1000, 32'hCD00_0000,
                   32'h0, 4'b0001, 32'h0000_00AB, 3, 1'b0};
        tbl[5] = '{32'h0000_2002, 32'hCAFE_F00D, 3'd2, 3, 2, 32'h2000, 4'b1100, 32'hF00D_0000,
                   32'h2004, 4'b0011, 32'h0000_CAFE, 6, 1'b0};
        tbl[6] = '{32'h0000_3000, 32'h0000_0055, 3'd3, 0, 0, 32'h0, 4'b0000, 32'h0,
                   32'h0, 4'b0000, 32'h0, 1, 1'b1};
        tbl[7] = '{32'h0000_1001, 32'hFFFF_FF77, 3'd0, 0, 1, 32'h1000, 4'b0010, 32'h0000_7700,
                   32'h0, 4'b0000, 32'h0, 2, 1'b0};
        tbl[8] = '{32'h0000_1001, 32'hFFFF_5AA5, 3'd1, 0, 1, 32'h1000, 4'b0110, 32'h005A_A500,
                   32'h0, 4'b0000, 32'h0, 2, 1'b0};

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.req_funct3 = '0;
        bus.mem_ready  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_store(tbl[i].addr, tbl[i].data, tbl[i].f3, tbl[i].wlo, 0);
            load_row(tbl[i]);
            compare($sformatf("vec%0d", i));
        end

        // Reset pulsed while the second half of a split SW is on the bus.
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h0000_1001;
        bus.req_data   = 32'h1122_3344;
        bus.req_funct3 = 3'd2;
        bus.mem_ready  = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rsthi_lo_we", {31'd0, bus.mem_we}, 32'd1);
        chk("rsthi_lo_addr", bus.mem_addr, 32'h1000);
        @(negedge clk);
        chk("rsthi_hi_we", {31'd0, bus.mem_we}, 32'd1);
        chk("rsthi_hi_addr", bus.mem_addr, 32'h1004);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rsthi_we_after", {31'd0, bus.mem_we}, 32'd0);
        chk("rsthi_ready_after", {31'd0, bus.req_ready}, 32'd1);
        chk("rsthi_done_after", {31'd0, bus.done}, 32'd0);
        chk("rsthi_be_after", {28'd0, bus.mem_be}, 32'd0);
        @(negedge clk);
        chk("rsthi_no_late_done", {31'd0, bus.done}, 32'd0);
        chk("rsthi_no_late_we", {31'd0, bus.mem_we}, 32'd0);
        run_store(tbl[0].addr, tbl[0].data, tbl[0].f3, 0, 0);
        load_row(tbl[0]);
        compare("post_reset_sw");

        for (int r = 0; r < 150; r++) begin
            logic [31:0] a, d;
            logic [2:0]  f3;
            int wl, wh, sel;
            sel = $urandom_range(0, 9);
            a   = (sel == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
            d   = $urandom;
            sel = $urandom_range(0, 9);
            f3  = (sel < 8) ? 3'(sel % 3) : 3'($urandom_range(3, 7));
            wl  = $urandom_range(0, 2);
            wh  = $urandom_range(0, 2);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_store(a, d, f3, wl, wh);
            model(a, d, f3, (exp_n_of(a, f3) == 2) ? wl + wh : ((f3 > 3'd2) ? 0 : wl));
            compare("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Number of distinct words touched by a store, used to total the wait cycles.
    function automatic int exp_n_of(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] last;
        if (f3 > 3'd2) return 0;
        last = a + ((1 << f3) - 1);
        return (last[31:2] != a[31:2]) ? 2 : 1;
    endfunction

endmodule
